// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared types and constants for the fractal scan controller
//
// Purpose: coordinate and iteration-count types, scan FSM state encoding, and
//          the saturated iteration value written for pixels that never return.
// Ports:   none (package)

package fractal_pkg;

  localparam int COORD_W = 16;
  localparam int ITER_W  = 8;

  // Signed Q4.12 complex-plane coordinate component.
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [ITER_W-1:0]         iter_t;

  // Count reported for a pixel treated as inside the set.
  localparam iter_t ITER_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/fractal_coord_acc.sv
// rtl/fractal_coord_acc.sv - pixel position counters and coordinate accumulators
//
// Purpose: tracks col/row of the current pixel, the matching x/y coordinate and
//          the linear framebuffer address, all without multipliers.
// Ports:   clk, rst            clock and asynchronous active-high reset
//          init                load start/step values, zero counters
//          advance             step to the next pixel in raster order
//          start_x..step_y     frame origin and per-column/per-row increments
//          x, y                coordinate of the current pixel
//          addr                row*H_RES + col of the current pixel
//          last                current pixel is the final one of the frame

module fractal_coord_acc
  import fractal_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  coord_t            start_x,
  input  coord_t            start_y,
  input  coord_t            step_x,
  input  coord_t            step_y,
  output coord_t            x,
  output coord_t            y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  coord_t            x_q, x_d, y_q, y_d;
  coord_t            sx_q, sx_d, dx_q, dx_d, dy_q, dy_d;
  logic              end_of_row;

  assign end_of_row = (col_q == CW'(H_RES - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    sx_d   = sx_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    if (init) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
      x_d    = start_x;
      y_d    = start_y;
      sx_d   = start_x;
      dx_d   = step_x;
      dy_d   = step_y;
    end else if (advance) begin
      // Raster order makes the linear address a plain increment.
      addr_d = addr_q + 1'b1;
      if (end_of_row) begin
        col_d = '0;
        row_d = row_q + 1'b1;
        x_d   = sx_q;
        y_d   = y_q + dy_q;
      end else begin
        col_d = col_q + 1'b1;
        x_d   = x_q + dx_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sx_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
      sx_q   <= sx_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;
  assign last = end_of_row && (row_q == RW'(V_RES - 1));

endmodule

// File: rtl/fractal_scan_ctrl.sv
// rtl/fractal_scan_ctrl.sv - raster scan sequencer feeding the fractal engine
//
// Purpose: walks an H_RES x V_RES grid, issues one coordinate request per pixel,
//          waits for the iteration count and writes it to the framebuffer.
//          Optional macro FRACTAL_SCAN_TIMEOUT_EN adds a WAIT timeout that
//          writes ITER_MAX after TIMEOUT cycles without a result.
// Ports:   Clk_100M, Reset                clock, asynchronous active-high reset
//          start, startX/Y, stepX/Y       frame start pulse and geometry
//          req_valid/req_ready/req_x/y    coordinate request channel
//          res_valid, res_iter            engine result (one-cycle pulse)
//          fb_we, fb_addr, fb_data        framebuffer write port
//          busy, done                     scan status, end-of-frame pulse

module fractal_scan_ctrl
  import fractal_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
`ifdef FRACTAL_SCAN_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic              start,
  input  coord_t            startX,
  input  coord_t            startY,
  input  coord_t            stepX,
  input  coord_t            stepY,
  output logic              req_valid,
  output coord_t            req_x,
  output coord_t            req_y,
  input  logic              req_ready,
  input  logic              res_valid,
  input  iter_t             res_iter,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output iter_t             fb_data,
  output logic              busy,
  output logic              done
);

  scan_state_e state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic        fb_we_q, fb_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  iter_t       data_q, data_d;
  logic        acc_init, acc_advance, acc_last;

`ifdef FRACTAL_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  fractal_coord_acc #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_acc (
    .clk    (Clk_100M),
    .rst    (Reset),
    .init   (acc_init),
    .advance(acc_advance),
    .start_x(startX),
    .start_y(startY),
    .step_x (stepX),
    .step_y (stepY),
    .x      (req_x),
    .y      (req_y),
    .addr   (fb_addr),
    .last   (acc_last)
  );

  // Outputs are registered: each *_d is the value for the state being entered.
  always_comb begin
    state_d     = state_q;
    req_valid_d = 1'b0;
    fb_we_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;
    data_d      = data_q;
    acc_init    = 1'b0;
    acc_advance = 1'b0;
`ifdef FRACTAL_SCAN_TIMEOUT_EN
    tmo_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_init    = 1'b1;
          busy_d      = 1'b1;
          req_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_valid_d = 1'b1;
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (res_valid) begin
          data_d  = res_iter;
          fb_we_d = 1'b1;
          state_d = ST_WRITE;
        end
`ifdef FRACTAL_SCAN_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          data_d  = ITER_MAX;
          fb_we_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_WRITE: begin
        acc_advance = 1'b1;
        if (acc_last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          req_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      fb_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
`ifdef FRACTAL_SCAN_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      fb_we_q     <= fb_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
`ifdef FRACTAL_SCAN_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_valid = req_valid_q;
  assign fb_we     = fb_we_q;
  assign fb_data   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fractal_scan_ctrl.sv
// tb/tb_fractal_scan_ctrl.sv - scoreboard bench for fractal_scan_ctrl on a 4x2 grid

module tb_fractal_scan_ctrl;

  localparam int H = 4;
  localparam int V = 2;

  logic        Clk_100M;
  logic        Reset;
  logic        start;
  logic [15:0] startX, startY, stepX, stepY;
  logic        req_valid;
  logic [15:0] req_x, req_y;
  logic        req_ready;
  logic        res_valid;
  logic [7:0]  res_iter;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [7:0]  fb_data;
  logic        busy;
  logic        done;

  fractal_scan_ctrl #(
    .H_RES (H),
    .V_RES (V),
    .ADDR_W(15)
`ifdef FRACTAL_SCAN_TIMEOUT_EN
    ,
    .TIMEOUT(10)
`endif
  ) dut (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .start    (start),
    .startX   (startX),
    .startY   (startY),
    .stepX    (stepX),
    .stepY    (stepY),
    .req_valid(req_valid),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_iter (res_iter),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .busy     (busy),
    .done     (done)
  );

  initial Clk_100M = 1'b0;
  always #5 Clk_100M = ~Clk_100M;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_req[$];
  logic [22:0] exp_wr[$];

  int   mon_req_cnt = 0;
  int   done_cnt    = 0;
  logic prev_we     = 1'b0;
  logic [14:0] prev_addr = '0;

  int   eng_cnt  = 0;
  int   eng_base = 0;
  logic eng_silent = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a transfer.
  always @(negedge Clk_100M) begin
    if (req_valid && req_ready) begin
      mon_req_cnt++;
      if (exp_req.size() == 0) chk("req_unexpected", {req_x, req_y}, 64'hDEAD);
      else chk("req_xy", {req_x, req_y}, exp_req.pop_front());
    end
    if (fb_we) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", {fb_addr, fb_data}, 64'hDEAD);
      else chk("wr_addr_data", {fb_addr, fb_data}, exp_wr.pop_front());
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last_we", {prev_we, prev_addr}, {1'b1, 15'd7});
      chk("busy_with_done", busy, 1);
    end
    prev_we   <= fb_we;
    prev_addr <= fb_addr;
  end

  // Engine model: answers one cycle after acceptance with the pixel index.
  initial begin
    res_valid = 1'b0;
    res_iter  = '0;
    forever begin
      @(negedge Clk_100M);
      if (req_valid && req_ready && !eng_silent && !Reset) begin
        @(posedge Clk_100M);
        #1;
        res_valid = 1'b1;
        res_iter  = 8'(eng_cnt - eng_base);
        eng_cnt++;
        @(posedge Clk_100M);
        #1;
        res_valid = 1'b0;
      end
    end
  end

  task automatic push_frame(input logic [15:0] sx, sy, dx, dy, input bit silent);
    logic [15:0] xv, yv;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        xv = sx + 16'(c) * dx;
        yv = sy + 16'(r) * dy;
        exp_req.push_back({xv, yv});
        exp_wr.push_back({15'(r * H + c), silent ? 8'hFF : 8'(r * H + c)});
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] sx, sy, dx, dy);
    @(posedge Clk_100M);
    #1;
    startX = sx; startY = sy; stepX = dx; stepY = dy;
    start = 1'b1;
    @(posedge Clk_100M);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] sx, sy, dx, dy,
                           input int stall, input bit repulse, input bit silent);
    int d0;
    int n;
    logic [31:0] hold;
    push_frame(sx, sy, dx, dy, silent);
    eng_base   = eng_cnt;
    eng_silent = silent;
    d0         = done_cnt;
    req_ready  = (stall == 0);
    pulse_start(sx, sy, dx, dy);
    chk("req_valid_after_start", req_valid, 1);
    chk("busy_after_start", busy, 1);
    if (stall > 0) begin
      hold = {req_x, req_y};
      repeat (stall) begin
        @(posedge Clk_100M);
        #1;
        chk("stall_hold", {req_valid, req_x, req_y}, {1'b1, hold});
      end
      req_ready = 1'b1;
    end
    if (repulse) begin
      repeat (6) @(posedge Clk_100M);
      pulse_start(16'h5555, 16'h5555, 16'h0101, 16'h0101);
    end
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge Clk_100M);
      #1;
      n++;
    end
    chk("frame_done_in_time", 64'(n < 400), 1);
    repeat (3) @(posedge Clk_100M);
    #1;
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("busy_idle", busy, 0);
    chk("req_left", 64'(exp_req.size()), 0);
    chk("wr_left", 64'(exp_wr.size()), 0);
    eng_silent = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    Reset = 1'b1; start = 1'b0; req_ready = 1'b1;
    startX = '0; startY = '0; stepX = '0; stepY = '0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_xy", {req_x, req_y}, 0);
    chk("rst_fb", {fb_we, fb_addr, fb_data}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    repeat (3) @(posedge Clk_100M);
    #1 Reset = 1'b0;

    run_frame(16'h0000, 16'h1000, 16'h0033, 16'h004C, 0, 0, 0);
    run_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 5, 0, 0);
    run_frame(16'h0000, 16'h1000, 16'h0033, 16'h004C, 0, 1, 0);
    run_frame(16'h7FF0, 16'h0000, 16'h0020, 16'h0010, 0, 0, 0);

    // Reset while waiting on pixel 3.
    push_frame(16'h0000, 16'h1000, 16'h0033, 16'h004C, 0);
    eng_base = eng_cnt;
    r0 = mon_req_cnt;
    pulse_start(16'h0000, 16'h1000, 16'h0033, 16'h004C);
    n = 0;
    while (mon_req_cnt < r0 + 4 && n < 200) begin
      @(posedge Clk_100M);
      #1;
      n++;
    end
    chk("reach_pixel3_wait", 64'(n < 200), 1);
    Reset = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {req_valid, req_x, req_y, fb_we, fb_addr, fb_data, busy, done}, 0);
    exp_req.delete();
    exp_wr.delete();
    repeat (3) @(posedge Clk_100M);
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk_100M);
    chk("idle_after_reset", {busy, req_valid}, 0);
    run_frame(16'h0000, 16'h1000, 16'h0033, 16'h004C, 0, 0, 0);

`ifdef FRACTAL_SCAN_TIMEOUT_EN
    run_frame(16'h0000, 16'h0000, 16'h0001, 16'h0001, 0, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
